// File: rtl/debounce_multi_if.sv
// Signal bundle for the N-channel debouncer: raw inputs and the shared delay in,
// debounced levels and edge pulses out. IRQ signals exist only with DEBOUNCE_IRQ_EN.
interface debounce_multi_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  logic [N-1:0]     in;
  logic [CNT_W-1:0] delay;
  logic [N-1:0]     out;
  logic [N-1:0]     rise;
  logic [N-1:0]     fall;
`ifdef DEBOUNCE_IRQ_EN
  logic [N-1:0]     irq_mask;
  logic [N-1:0]     irq_clr;
  logic [N-1:0]     irq_status;
  logic             irq;
`endif

  modport master (
    output in,
    output delay,
    input  out,
    input  rise,
    input  fall
`ifdef DEBOUNCE_IRQ_EN
    ,
    output irq_mask,
    output irq_clr,
    input  irq_status,
    input  irq
`endif
  );

  modport slave (
    input  in,
    input  delay,
    output out,
    output rise,
    output fall
`ifdef DEBOUNCE_IRQ_EN
    ,
    input  irq_mask,
    input  irq_clr,
    output irq_status,
    output irq
`endif
  );
endinterface

// File: rtl/debounce_multi.sv
// N-channel debouncer: 2-flop synchroniser, per-channel stability counter with a
// shared runtime delay, registered level and rise/fall pulses. Optional DEBOUNCE_IRQ_EN.
module debounce_multi #(
  parameter int N       = 4,
  parameter int CNT_W   = 8,
  parameter bit RST_VAL = 1'b0
) (
  input logic            clock,
  input logic            reset_n,
  debounce_multi_if.slave bus
);

  logic [N-1:0]     s1_q, s2_q;
  logic [N-1:0]     out_q, out_d;
  logic [N-1:0]     rise_q, rise_d;
  logic [N-1:0]     fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];

  // NOTE: every variable gets a default before the branches so no latch is inferred.
  always_comb begin
    out_d  = out_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != out_q[i]) begin
        // The >= compare bounds the counter and lets a lowered delay commit at once.
        if (cnt_q[i] >= bus.delay) begin
          out_d[i]  = s2_q[i];
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= {N{RST_VAL}};
      s2_q   <= {N{RST_VAL}};
      out_q  <= {N{RST_VAL}};
      rise_q <= '0;
      fall_q <= '0;
      // NOTE: the counter array is only N small registers, so it is reset like any
      // other state; a large RAM would normally be left unreset.
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      s1_q   <= bus.in;
      s2_q   <= s1_q;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.out  = out_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;

`ifdef DEBOUNCE_IRQ_EN
  logic [N-1:0] irq_status_q, irq_status_d;
  logic         irq_q, irq_d;

  // Sticky status: a pulse from the previous cycle wins over a write-1-clear.
  always_comb begin
    irq_status_d = (irq_status_q & ~bus.irq_clr) | rise_q | fall_q;
    irq_d        = |(irq_status_q & bus.irq_mask);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq_status_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      irq_status_q <= irq_status_d;
      irq_q        <= irq_d;
    end
  end

  assign bus.irq_status = irq_status_q;
  assign bus.irq        = irq_q;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi (N=4, CNT_W=8, RST_VAL=0); expected values are
// hand-derived from the delay+3 latency rule. Covers IRQ paths when DEBOUNCE_IRQ_EN is set.
module tb_debounce_multi;

  localparam int N     = 4;
  localparam int CNT_W = 8;

  logic clock;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  debounce_multi_if #(.N(N), .CNT_W(CNT_W)) bus ();

  debounce_multi #(.N(N), .CNT_W(CNT_W), .RST_VAL(1'b0)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Advance n posedges; outputs are then read 1 time unit after the last edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    logic seen_out, seen_rise;

    reset_n   = 1'b0;
    bus.in    = 4'hF;
    bus.delay = 8'd5;
`ifdef DEBOUNCE_IRQ_EN
    bus.irq_mask = '0;
    bus.irq_clr  = '0;
`endif

    // Reset held with all inputs high
    step(3);
    check("rst_out",  bus.out,  4'h0);
    check("rst_rise", bus.rise, 4'h0);
    check("rst_fall", bus.fall, 4'h0);

    // Release: commit lands exactly delay+3 = 8 edges later
    reset_n = 1'b1;
    step(7);
    check("rel_out_e7", bus.out, 4'h0);
    step(1);
    check("rel_out_e8",  bus.out,  4'hF);
    check("rel_rise_e8", bus.rise, 4'hF);
    check("rel_fall_e8", bus.fall, 4'h0);
    step(1);
    check("rel_rise_e9", bus.rise, 4'h0);

    // Async reset entry clears immediately, no pulse on entry or exit
    reset_n = 1'b0;
    bus.in  = 4'h0;
    #1;
    check("async_rst_out",  bus.out,  4'h0);
    check("async_rst_fall", bus.fall, 4'h0);
    step(2);
    reset_n = 1'b1;
    step(3);
    check("rst_exit_out",  bus.out,  4'h0);
    check("rst_exit_fall", bus.fall, 4'h0);

    // Glitch reject: 8 high cycles against delay=10
    bus.delay = 8'd10;
    bus.in    = 4'b0001;
    step(8);
    bus.in    = 4'b0000;
    seen_out  = 1'b0;
    seen_rise = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      seen_out  = seen_out  | bus.out[0];
      seen_rise = seen_rise | bus.rise[0];
    end
    check("glitch_out",  32'(seen_out),  32'd0);
    check("glitch_rise", 32'(seen_rise), 32'd0);
    // Counter must have cleared: a real step still needs the full delay+3 = 13 edges
    bus.in = 4'b0001;
    step(12);
    check("noglitch_e12", bus.out, 4'b0000);
    step(1);
    check("noglitch_e13",      bus.out,  4'b0001);
    check("noglitch_rise_e13", bus.rise, 4'b0001);

    // Clean step with delay=0: 3-edge latency
    bus.delay = 8'd0;
    bus.in    = 4'b0011;
    step(2);
    check("d0_out_e2", bus.out, 4'b0001);
    step(1);
    check("d0_out_e3",  bus.out,  4'b0011);
    check("d0_rise_e3", bus.rise, 4'b0010);
    step(1);
    check("d0_rise_e4", bus.rise, 4'b0000);
    bus.in = 4'b0001;
    step(3);
    check("d0_fall_out",  bus.out,  4'b0001);
    check("d0_fall_fall", bus.fall, 4'b0010);
    check("d0_fall_rise", bus.rise, 4'b0000);

    // Independent channels, delay=3: ch2 at t, ch3 at t+1
    bus.delay = 8'd3;
    bus.in    = 4'b0101;
    step(1);
    bus.in    = 4'b1101;
    step(4);
    check("ind_out_e5", bus.out, 4'b0001);
    step(1);
    check("ind_out_e6",  bus.out,  4'b0101);
    check("ind_rise_e6", bus.rise, 4'b0100);
    step(1);
    check("ind_out_e7",  bus.out,  4'b1101);
    check("ind_rise_e7", bus.rise, 4'b1000);
    step(1);
    check("ind_rise_e8", bus.rise, 4'b0000);

    // Lowering delay mid-count commits on the next edge
    bus.delay = 8'd200;
    bus.in    = 4'b1111;
    step(52);
    check("low_out_pre", bus.out, 4'b1101);
    bus.delay = 8'd20;
    step(1);
    check("low_out",  bus.out,  4'b1111);
    check("low_rise", bus.rise, 4'b0010);

    // All-ones delay: 256 stable cycles, commit at edge 258
    bus.delay = 8'hFF;
    bus.in    = 4'b1101;
    step(257);
    check("max_out_e257", bus.out, 4'b1111);
    step(1);
    check("max_out_e258",  bus.out,  4'b1101);
    check("max_fall_e258", bus.fall, 4'b0010);
    step(1);
    check("max_fall_e259", bus.fall, 4'b0000);

    // Simultaneous commits on all channels in both directions
    bus.delay = 8'd1;
    bus.in    = 4'b0010;
    step(3);
    check("sim_out_e3", bus.out, 4'b1101);
    step(1);
    check("sim_out_e4",  bus.out,  4'b0010);
    check("sim_rise_e4", bus.rise, 4'b0010);
    check("sim_fall_e4", bus.fall, 4'b1101);
    step(2);

`ifdef DEBOUNCE_IRQ_EN
    bus.irq_clr = 4'hF;
    step(1);
    bus.irq_clr = 4'h0;
    check("irq_clear_all", bus.irq_status, 4'h0);

    bus.irq_mask = 4'b0010;
    bus.delay    = 8'd0;
    bus.in       = 4'b0000;
    step(3);
    check("irq_fall_pulse", bus.fall,       4'b0010);
    check("irq_status_e3",  bus.irq_status, 4'b0000);
    step(1);
    check("irq_status_e4", bus.irq_status, 4'b0010);
    check("irq_e4",        32'(bus.irq),   32'd0);
    step(1);
    check("irq_e5", 32'(bus.irq), 32'd1);
    bus.irq_clr = 4'b0010;
    step(1);
    bus.irq_clr = 4'b0000;
    check("irq_clr_status", bus.irq_status, 4'b0000);
    step(1);
    check("irq_clr_irq", 32'(bus.irq), 32'd0);

    // Clear in the same cycle as a new set: set wins
    bus.in = 4'b0010;
    step(3);
    check("irq_rise_pulse", bus.rise, 4'b0010);
    bus.irq_clr = 4'b0010;
    step(1);
    bus.irq_clr = 4'b0000;
    check("irq_set_wins", bus.irq_status, 4'b0010);
    step(1);
    check("irq_after_set", 32'(bus.irq), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- N-channel, parametrised successor to the single-bit debouncer.
- Each channel synchronises a raw asynchronous input through 2 flops.
- A per-channel stability counter accepts a new level only after it has held for a runtime-programmable number of clocks.
- Outputs: a debounced level plus one-cycle rise/fall pulses per channel, for button/switch banks feeding control FSMs.

Parameters:
- N, 4, number of independent channels (1..32).
- CNT_W, 8, width of the delay input and of each stability counter.
- RST_VAL, 0, reset level of every sync flop and debounced output (0 or 1, applied to all channels).

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset_n  in  1  asynchronous active-low reset; assert async, deassert synchronous to clock externally.
- in  in  N  raw, asynchronous inputs, one per channel.
- delay  in  CNT_W  required stable cycles minus one; shared by all channels; sampled every cycle.
- out  out  N  debounced levels.
- rise  out  N  one-cycle pulse when out[i] goes 0->1.
- fall  out  N  one-cycle pulse when out[i] goes 1->0.

Behaviour:
- Reset (reset_n=0, async):
  - sync stage-1/stage-2 flops = {N{RST_VAL}}, out = {N{RST_VAL}}.
  - All counters = 0; rise = fall = 0.
- Synchroniser:
  - s1[i] <= in[i]; s2[i] <= s1[i].
  - Only s2 feeds the rest of the logic.
- Per channel i, each posedge, mismatch = (s2[i] != out[i]):
  - If !mismatch: cnt[i] <= 0; out holds; no pulse.
  - If mismatch and cnt[i] >= delay: out[i] <= s2[i]; cnt[i] <= 0; rise[i] or fall[i] = 1 for exactly that one cycle (registered, same edge as out update).
  - If mismatch and cnt[i] < delay: cnt[i] <= cnt[i]+1.
- Any return to agreement before the threshold clears the counter (glitch rejected); there is no partial credit.
- Latency: a clean input step appears on out exactly delay+3 posedges after the first edge that samples it. delay=0 gives 3 cycles.
- Counter never wraps:
  - bounded by the >= compare.
  - Lowering delay mid-count makes the channel commit on the next mismatching cycle.
  - delay = all-ones is legal: 2^CNT_W stable cycles.
- Channels are fully independent; simultaneous commits on several channels are all honoured in the same cycle.
- rise and fall are never both 1 for a channel; out toggles at most once per cycle.
- Reset mid-count: all state returns to reset values immediately, with no pulse emitted on reset entry or exit.
- First cycles after reset release: if in != RST_VAL, normal debounce applies (commit after delay+3), producing a rise/fall pulse.

Optional Feature:
- Macro: DEBOUNCE_IRQ_EN.
- Defined — adds ports:
  - irq_mask in N
  - irq_clr in N
  - irq_status out N
  - irq out 1
- Defined — behaviour:
  - irq_status[i] is sticky; set on the cycle after rise[i]|fall[i].
  - Cleared by irq_clr[i]=1 (write-1-clear); set wins over a simultaneous clear.
  - irq = |(irq_status & irq_mask), registered. It asserts 2 clocks after the pulse, 1 clock after status.
  - irq_status = 0 and irq = 0 on reset.
- Not defined: ports absent, no extra logic.

Test Plan:
- Reset: reset_n=0 with RST_VAL=0, in=4'hF. Required: out=0, rise=fall=0 during reset. After release with delay=5: out=4'hF exactly 8 posedges later, plus a single rise pulse on all 4 channels.
- Glitch reject: delay=10, in[0] pulsed high for 8 clocks then low. Required: out[0] stays 0, no rise; cnt clears.
- Clean step, delay=0: in[1] 0->1. Required: out[1]=1 on the 3rd posedge, rise[1] high for 1 cycle; the reverse step gives fall[1].
- Independent channels, delay=3: in[2] rises at t, in[3] rises at t+1. Required: out[2] at t+6, out[3] at t+7, each with its own single-cycle pulse; other channels static.
- Delay lowered mid-count: delay=200, mismatch held 50 cycles, then delay=20. Required: commit on the next posedge. Then delay=8'hFF: commit after 256 stable cycles, no wrap.
- DEBOUNCE_IRQ_EN: mask=4'b0010, debounce channel 1. Required: irq_status[1]=1 and irq=1 one cycle later; irq_clr[1] pulse clears both. irq_clr asserted in the same cycle as a new set leaves status=1.
